// File: rtl/reset_release_sequencer.sv
// Reset release sequencer: waits for the upstream active-low reset to stay
// released for MINHOLD cycles, then releases NSTAGES downstream reset domains
// one at a time. Each stage waits for its acknowledge, or for a timeout, before
// the next stage is released. The first stage that times out is latched.

// One downstream reset bit. Clear beats set, so an abort in the same cycle as a
// release keeps the domain in reset.
module reset_release_stage (
  input  logic CLK,
  input  logic RST,
  input  logic clr,
  input  logic set,
  output logic rst_n
);
  // Registered, active-low stage reset
  always_ff @(posedge CLK) begin
    if (RST || clr) rst_n <= 1'b0;
    else if (set)   rst_n <= 1'b1;
  end
endmodule

module reset_release_sequencer #(
  parameter int NSTAGES = 4,
  parameter int MINHOLD = 2,
  parameter int TIMEOUT = 16,
  parameter int CNTW    = 8
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               IN_RST_N,
  input  logic               SW_REQ,
  input  logic [NSTAGES-1:0] STAGE_ACK,
  output logic [NSTAGES-1:0] STAGE_RST_N,
  output logic               ALL_READY,
  output logic               TIMEOUT_ERR,
  output logic [7:0]         ERR_STAGE
);
  localparam int IW = (NSTAGES > 1) ? $clog2(NSTAGES) : 1;

  typedef enum logic [1:0] {HOLD, RELEASE, WAIT_ACK, READY} state_t;

  state_t          state;
  logic [CNTW-1:0] hold_cnt;
  logic [CNTW-1:0] timer;
  logic [IW-1:0]   idx;

  logic abort;
  logic last_stage;
  logic acked;
  logic expired;

  assign abort      = !IN_RST_N || SW_REQ;
  assign last_stage = (idx == IW'(NSTAGES - 1));
  assign acked      = STAGE_ACK[idx];
  assign expired    = (timer == CNTW'(TIMEOUT - 1));

  // Per-stage reset registers; stage g is released while the FSM sits in RELEASE for it
  for (genvar g = 0; g < NSTAGES; g++) begin : g_stage
    reset_release_stage u_stage (
      .CLK   (CLK),
      .RST   (RST),
      .clr   (abort),
      .set   ((state == RELEASE) && (idx == IW'(g))),
      .rst_n (STAGE_RST_N[g])
    );
  end

  // Sequencing FSM with registered readiness and sticky first-timeout report
  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= HOLD;
      hold_cnt    <= '0;
      timer       <= '0;
      idx         <= '0;
      ALL_READY   <= 1'b0;
      TIMEOUT_ERR <= 1'b0;
      ERR_STAGE   <= '0;
    end else if (abort) begin
      // Error report survives an abort; only RST clears it
      state     <= HOLD;
      hold_cnt  <= '0;
      timer     <= '0;
      idx       <= '0;
      ALL_READY <= 1'b0;
    end else begin
      case (state)
        HOLD: begin
          if (hold_cnt == CNTW'(MINHOLD - 1)) begin
            state    <= RELEASE;
            hold_cnt <= '0;
          end else if (hold_cnt != '1) begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        RELEASE: begin
          timer <= '0;
          state <= WAIT_ACK;
        end
        WAIT_ACK: begin
          if (acked || expired) begin
            // A timed-out stage advances exactly like an acked one
            if (!acked && !TIMEOUT_ERR) begin
              TIMEOUT_ERR <= 1'b1;
              ERR_STAGE   <= 8'(idx);
            end
            timer <= '0;
            if (last_stage) begin
              state     <= READY;
              ALL_READY <= 1'b1;
            end else begin
              idx   <= idx + IW'(1);
              state <= RELEASE;
            end
          end else if (timer != '1) begin
            timer <= timer + 1'b1;
          end
        end
        READY: begin
          ALL_READY <= 1'b1;
        end
        default: state <= HOLD;
      endcase
    end
  end
endmodule
